// File: rtl/alu_pkg.sv
// Shared ALU types: operand widths, rotate request payload and requester id.
package alu_pkg;

   localparam int unsigned DATA_W = 8;
   localparam int unsigned AMT_W  = 3;

   typedef logic req_id_t;

   typedef struct packed {
      logic [DATA_W-1:0] data;
      logic [AMT_W-1:0]  amt;
      logic              dir;
   } rot_req_t;

endpackage

// File: rtl/rotate_arbiter_rotateShifter.sv
// rotateShifter: combinational 8-bit left rotate by a 3-bit amount.
module rotateShifter
   import alu_pkg::*;
(
   input  logic [DATA_W-1:0] data_i,
   input  logic [AMT_W-1:0]  amt_i,
   output logic [DATA_W-1:0] data_o
);

   logic [DATA_W-1:0] stage1_c;
   logic [DATA_W-1:0] stage2_c;

   // Log-shifter: rotate by 1, 2, 4 selected by each amount bit.
   always_comb begin
      stage1_c = amt_i[0] ? {data_i[6:0], data_i[7]}     : data_i;
      stage2_c = amt_i[1] ? {stage1_c[5:0], stage1_c[7:6]} : stage1_c;
      data_o   = amt_i[2] ? {stage2_c[3:0], stage2_c[7:4]} : stage2_c;
   end

endmodule

// File: rtl/rotate_arbiter.sv
// rotate_arbiter: round-robin share of one rotateShifter between two requesters.
// Define ROT_ARB_RIGHT_EN to add per-requester dir ports (1 = rotate right).
module rotate_arbiter
   import alu_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              req0_valid,
   output logic              req0_ready,
   input  logic [DATA_W-1:0] req0_data,
   input  logic [AMT_W-1:0]  req0_amt,
`ifdef ROT_ARB_RIGHT_EN
   input  logic              req0_dir,
`endif
   input  logic              req1_valid,
   output logic              req1_ready,
   input  logic [DATA_W-1:0] req1_data,
   input  logic [AMT_W-1:0]  req1_amt,
`ifdef ROT_ARB_RIGHT_EN
   input  logic              req1_dir,
`endif
   output logic              res_valid,
   input  logic              res_ready,
   output logic [DATA_W-1:0] res_data,
   output logic              res_id
);

   rot_req_t          req0_s;
   rot_req_t          req1_s;
   rot_req_t          sel_s;
   logic              free_c;
   logic              gnt_any_c;
   req_id_t           gnt_id_c;
   logic              accept_c;
   logic [AMT_W-1:0]  rot_amt_c;
   logic [DATA_W-1:0] rot_data_c;

   logic              res_valid_q, res_valid_d;
   logic [DATA_W-1:0] res_data_q,  res_data_d;
   req_id_t           res_id_q,    res_id_d;
   req_id_t           last_q,      last_d;

   // Without the right-rotate option the direction is tied to left.
   always_comb begin
      req0_s.data = req0_data;
      req0_s.amt  = req0_amt;
      req1_s.data = req1_data;
      req1_s.amt  = req1_amt;
`ifdef ROT_ARB_RIGHT_EN
      req0_s.dir  = req0_dir;
      req1_s.dir  = req1_dir;
`else
      req0_s.dir  = 1'b0;
      req1_s.dir  = 1'b0;
`endif
   end

   // Round-robin grant: a tie goes to the requester not served last.
   always_comb begin
      free_c     = ~res_valid_q | res_ready;
      gnt_any_c  = req0_valid | req1_valid;
      gnt_id_c   = (req0_valid & req1_valid) ? ~last_q : req1_valid;
      accept_c   = ~rst & free_c & gnt_any_c;
      req0_ready = accept_c & (gnt_id_c == 1'b0);
      req1_ready = accept_c & (gnt_id_c == 1'b1);
      sel_s      = gnt_id_c ? req1_s : req0_s;
      rot_amt_c  = sel_s.dir ? AMT_W'(3'd0 - sel_s.amt) : sel_s.amt;
   end

   rotateShifter u_rot (
      .data_i (sel_s.data),
      .amt_i  (rot_amt_c),
      .data_o (rot_data_c)
   );

   // Output slot: a new accept overwrites, otherwise a drain just clears valid.
   always_comb begin
      res_valid_d = res_valid_q;
      res_data_d  = res_data_q;
      res_id_d    = res_id_q;
      last_d      = last_q;
      if (accept_c) begin
         res_valid_d = 1'b1;
         res_data_d  = rot_data_c;
         res_id_d    = gnt_id_c;
         last_d      = gnt_id_c;
      end else if (res_ready) begin
         res_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         res_valid_q <= 1'b0;
         res_data_q  <= '0;
         res_id_q    <= 1'b0;
         last_q      <= 1'b1;
      end else begin
         res_valid_q <= res_valid_d;
         res_data_q  <= res_data_d;
         res_id_q    <= res_id_d;
         last_q      <= last_d;
      end
   end

   assign res_valid = res_valid_q;
   assign res_data  = res_data_q;
   assign res_id    = res_id_q;

endmodule
